// File: rtl/pipeline_stall_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use stalls, branch flushes,
// data-memory wait freezes with a watchdog, and a counted drain into the halted state.
module pipeline_stall_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_halt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write_en,
  output logic              pr1_write_en,
  output logic              pr1_flush,
  output logic              pr2_flush,
  output logic              pr3_hold,
  output logic              pr4_bubble,
  output logic              halted,
  output logic              mem_error,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               mem_error_q, mem_error_d;

  logic freeze;
  logic load_use;

  assign freeze   = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    pc_write_en  = 1'b1;
    pr1_write_en = 1'b1;
    pr1_flush    = 1'b0;
    pr2_flush    = 1'b0;
    pr3_hold     = 1'b0;
    pr4_bubble   = 1'b0;
    case (state_q)
      StRun, StDrain: begin
        if (freeze) begin
          // Outstanding memory access: hold everything upstream of MEM, bubble into WB.
          pc_write_en  = 1'b0;
          pr1_write_en = 1'b0;
          pr3_hold     = 1'b1;
          pr4_bubble   = 1'b1;
        end else if (state_q == StDrain) begin
          pc_write_en = 1'b0;
          pr1_flush   = 1'b1;
          pr2_flush   = 1'b1;
        end else if (ex_branch_taken) begin
          pr1_flush = 1'b1;
          pr2_flush = 1'b1;
        end else if (load_use) begin
          pc_write_en  = 1'b0;
          pr1_write_en = 1'b0;
          pr2_flush    = 1'b1;
        end
      end
      StHalted: begin
        pc_write_en  = 1'b0;
        pr1_write_en = 1'b0;
        pr2_flush    = 1'b1;
        pr3_hold     = 1'b1;
        pr4_bubble   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    mem_error_d   = mem_error_q;
    stall_count_d = stall_count_q;
    wait_cnt_d    = (freeze && state_q != StHalted) ? wait_cnt_q + 1'b1 : '0;

    if (state_q != StHalted && !pc_write_en && stall_count_q != '1) begin
      stall_count_d = stall_count_q + 1'b1;
    end

    if (state_q != StHalted && freeze && wait_cnt_q == WAIT_LAST) begin
      state_d     = StHalted;
      mem_error_d = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          // A halt behind a taken branch is wrong-path and never drains.
          if (!freeze && id_halt && !ex_branch_taken) begin
            state_d     = StDrain;
            drain_cnt_d = DRAIN_INIT;
          end
        end
        StDrain: begin
          if (!freeze) begin
            if (drain_cnt_q <= DRAIN_W'(1)) begin
              state_d = StHalted;
            end else begin
              drain_cnt_d = drain_cnt_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      stall_count_q <= '0;
      mem_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      stall_count_q <= stall_count_d;
      mem_error_q   <= mem_error_d;
    end
  end

  assign halted      = (state_q == StHalted);
  assign mem_error   = mem_error_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central hazard and sequencing controller for the five-stage pipeline.
- Decides every cycle whether the PC and each pipeline register (PR1 IF/ID, PR2 ID/EX, PR3 EX/MEM, PR4 MEM/WB) loads, holds or flushes.
- Handles load-use stalls, taken-branch flushes, multi-cycle data-memory waits with a watchdog, and an orderly halt drain.
- Sits beside the pipeline registers; consumes ID/EX/MEM stage fields and drives their enables.

Parameters:
REG_AW, 5, register-address width.
MEM_TIMEOUT, 64, max consecutive frozen memory-wait cycles before error (>=2).
DRAIN_CYCLES, 3, cycles allowed for the pipeline to empty after a halt.
CNT_W, 16, width of stall performance counter.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  reset, asynchronous, active-low.
id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID.
id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads rs1/rs2.
id_halt  in  1  instruction in ID is HALT.
ex_mem_read  in  1  instruction in EX is a load.
ex_rd  in  REG_AW  destination register of the EX instruction.
ex_branch_taken  in  1  branch resolved taken in EX.
mem_req  in  1  MEM-stage instruction accesses data memory (read or write).
mem_ready  in  1  data memory completes the access this cycle.
pc_write_en  out  1  PC loads next value.
pr1_write_en  out  1  IF/ID loads.
pr1_flush  out  1  IF/ID loads NOP (wins over write_en).
pr2_flush  out  1  ID/EX loads bubble (all control bits 0).
pr3_hold  out  1  EX/MEM keeps its contents.
pr4_bubble  out  1  MEM/WB loads bubble.
halted  out  1  core stopped.
mem_error  out  1  sticky; memory watchdog expired.
stall_count  out  CNT_W  saturating count of cycles with pc_write_en=0 outside HALTED.

Behaviour:
- States: RUN, DRAIN, HALTED. wait_cnt (ceil log2 MEM_TIMEOUT+1 bits), drain_cnt, stall_count, mem_error are registered.
- Control outputs are combinational from state and inputs. Default in RUN: pc_write_en=1, pr1_write_en=1, all flush/hold/bubble=0.
- Priority per cycle, highest first:
  1. freeze = mem_req & ~mem_ready: pc_write_en=0, pr1_write_en=0, pr2_flush=0, pr3_hold=1, pr4_bubble=1. Everything upstream holds; branch and load-use are ignored this cycle.
  2. ex_branch_taken: pc_write_en=1, pr1_flush=1, pr2_flush=1. Load-use is suppressed (the ID instruction is wrong-path).
  3. load-use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)): pc_write_en=0, pr1_write_en=0, pr2_flush=1. Exactly one bubble per load.
- mem_ready=1 ends a freeze combinationally in that same cycle; rules 2 and 3 then apply normally.
- Watchdog:
  - wait_cnt increments each freeze cycle and clears on any non-freeze cycle.
  - When freeze holds with wait_cnt==MEM_TIMEOUT-1, next state is HALTED and mem_error<=1.
- Halt:
  - In RUN, id_halt=1 with no freeze and no branch: next state DRAIN, drain_cnt<=DRAIN_CYCLES.
  - If the branch is taken in that cycle, the halt is on a wrong path and is ignored.
- DRAIN:
  - pc_write_en=0, pr1_flush=1, pr2_flush=1. Downstream stages advance.
  - Freeze still applies and pauses drain_cnt.
  - drain_cnt decrements on non-freeze cycles; at 1 the next state is HALTED.
  - The watchdog stays active.
- HALTED: pc_write_en=0, pr1_write_en=0, pr2_flush=1, pr3_hold=1, pr4_bubble=1, halted=1. Left only by reset.
- stall_count increments when pc_write_en=0 and state!=HALTED. It saturates at all-ones.
- Reset (asserted at any time, including mid-freeze or mid-drain):
  - state=RUN; wait_cnt, drain_cnt, stall_count = 0; mem_error=0; halted=0.
  - Outputs then take RUN defaults: pc_write_en=1, pr1_write_en=1, others 0.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=7, id_use_rs2=1, id_rs2=7 for one cycle -> pc_write_en=0, pr1_write_en=0, pr2_flush=1 for exactly 1 cycle; stall_count=1. Repeat with ex_rd=0 -> no stall.
- Branch vs load-use in the same cycle: both conditions true -> pr1_flush=1, pr2_flush=1, pc_write_en=1, no stall; stall_count unchanged.
- Memory wait: mem_req=1, mem_ready low for 5 cycles then high:
  - pr3_hold=1 and pr4_bubble=1 for 5 cycles; normal on the 6th cycle.
  - stall_count=5; mem_error=0.
- Watchdog: MEM_TIMEOUT=8, mem_ready held low -> after 8 frozen cycles, halted=1 and mem_error=1; both persist until rst is asserted low.
- Halt drain: id_halt=1 in RUN; insert a 2-cycle freeze during DRAIN -> halted=1 after 3+2 cycles; pc_write_en=0 throughout. id_halt with ex_branch_taken in the same cycle -> stays in RUN.
- Async reset mid-DRAIN: assert rst between clock edges -> immediately halted=0, pc_write_en=1, stall_count=0.
